// File: rtl/sha2_pkg.sv
// Shared constants for the SHA-2 sigma engine: function-select encodings and
// the rotate/shift amounts for the 256 and 512 variants, indexed by select.
package sha2_pkg;

    localparam logic [1:0] SEL_BS0 = 2'd0;
    localparam logic [1:0] SEL_BS1 = 2'd1;
    localparam logic [1:0] SEL_SS0 = 2'd2;
    localparam logic [1:0] SEL_SS1 = 2'd3;

    // Third entry of the small-sigma rows is a logical shift, not a rotation.
    localparam int ROT_256 [4][3] = '{'{2, 13, 22}, '{6, 11, 25}, '{7, 18, 3}, '{17, 19, 10}};
    localparam int ROT_512 [4][3] = '{'{28, 34, 39}, '{14, 18, 41}, '{1, 8, 7}, '{19, 61, 6}};

    function automatic logic is_small_sigma(input logic [1:0] sel);
        return (sel == SEL_SS0) || (sel == SEL_SS1);
    endfunction

endpackage

// File: rtl/sha2_sigma_comb.sv
// Combinational SHA-2 sigma: two rotations plus a rotation (S0/S1) or a
// logical right shift (s0/s1), XORed together.
module sha2_sigma_comb
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        sel,
    output logic [WORD_W-1:0] result
);

    function automatic logic [WORD_W-1:0] right_cyclic_shift(input logic [WORD_W-1:0] x,
                                                            input int amt);
        return (x >> amt) | (x << (WORD_W - amt));
    endfunction

    int amt_a;
    int amt_b;
    int amt_c;

    always_comb begin
        amt_a = ROT_256[sel][0];
        amt_b = ROT_256[sel][1];
        amt_c = ROT_256[sel][2];
        if (WORD_W == 64) begin
            amt_a = ROT_512[sel][0];
            amt_b = ROT_512[sel][1];
            amt_c = ROT_512[sel][2];
        end
        result = right_cyclic_shift(word, amt_a) ^ right_cyclic_shift(word, amt_b)
               ^ (is_small_sigma(sel) ? (word >> amt_c) : right_cyclic_shift(word, amt_c));
    end

endmodule

// File: rtl/sha2_sigma_pipe.sv
// Pipelined SHA-2 sigma engine with valid/ready handshake and a tag carried
// alongside each word; the ready chain propagates combinationally from the output.
module sha2_sigma_pipe
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [1:0]        in_sel,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("sha2_sigma_pipe: WORD_W must be 32 or 64");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("sha2_sigma_pipe: DEPTH must be in 1..4");
    end

    logic [WORD_W-1:0] sigma_word;
    logic [DEPTH-1:0]  v_all;

    sha2_sigma_comb #(.WORD_W(WORD_W)) u_sigma (
        .word   (in_word),
        .sel    (in_sel),
        .result (sigma_word)
    );

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic              v;
        logic [WORD_W-1:0] w;
        logic [TAG_W-1:0]  t;
        logic              src_v;
        logic [WORD_W-1:0] src_w;
        logic [TAG_W-1:0]  src_t;
        logic              en;
        logic              en_nxt;

        if (k == 1) begin : g_src
            assign src_v = in_valid;
            assign src_w = sigma_word;
            assign src_t = in_tag;
        end else begin : g_src
            assign src_v = g_stage[k-1].v;
            assign src_w = g_stage[k-1].w;
            assign src_t = g_stage[k-1].t;
        end

        // A stage may load when it is empty or its content moves on this cycle.
        if (k == DEPTH) begin : g_nxt
            assign en_nxt = out_ready;
        end else begin : g_nxt
            assign en_nxt = g_stage[k+1].en;
        end

        assign en         = !v | en_nxt;
        assign v_all[k-1] = v;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v <= 1'b0;
                w <= '0;
                t <= '0;
            end else if (en) begin
                v <= src_v;
                if (src_v) begin
                    w <= src_w;
                    t <= src_t;
                end
            end
        end
    end

    assign in_ready  = g_stage[1].en;
    assign out_valid = g_stage[DEPTH].v;
    assign out_word  = g_stage[DEPTH].w;
    assign out_tag   = g_stage[DEPTH].t;
    assign busy      = |v_all;

endmodule
